// File: rtl/online_digit_reg.sv
// Digit-serial operand register for an online (MSD-first) signed-digit multiplier.
// Collects one radix-2 signed digit of X and of Y per handshake and exposes them as
// MSD-aligned parallel plus/minus prefix vectors. Unwritten positions read as 0.
// Optional feature macro: ONLINE_DIGIT_CHECK_EN adds the dig_err output and squashes
// the undefined digit 11 to 00 on store.
module online_digit_reg #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            x_digit,
  input  logic [1:0]            y_digit,
  output logic [NUM_DIGITS-1:0] x_plus,
  output logic [NUM_DIGITS-1:0] x_minus,
  output logic [NUM_DIGITS-1:0] y_plus,
  output logic [NUM_DIGITS-1:0] y_minus,
  output logic [CNT_W-1:0]      digit_cnt,
  output logic                  done
`ifdef ONLINE_DIGIT_CHECK_EN
  ,
  output logic                  dig_err
`endif
);

  typedef enum logic [1:0] {StIdle, StLoad, StFull} state_e;

  localparam logic [NUM_DIGITS-1:0] MsdBit   = {1'b1, {(NUM_DIGITS-1){1'b0}}};
  localparam logic [CNT_W-1:0]      LastIdx  = CNT_W'(NUM_DIGITS - 1);

  state_e                  state_q;
  logic                    accept;
  logic                    last;
  logic [NUM_DIGITS-1:0]   pos;
  logic [1:0]              x_eff;
  logic [1:0]              y_eff;

  assign in_ready = (state_q == StLoad);
  // start wins over a coincident digit, which is dropped
  assign accept   = in_valid & in_ready & ~start;
  assign last     = (digit_cnt == LastIdx);
  // one-hot write position: digit k lands at bit NUM_DIGITS-1-k
  assign pos      = MsdBit >> digit_cnt;

  // Digit sanitising: 11 has no signed-digit value
`ifdef ONLINE_DIGIT_CHECK_EN
  logic bad_digit;

  always_comb begin
    x_eff = x_digit;
    y_eff = y_digit;
    if (x_digit == 2'b11) x_eff = 2'b00;
    if (y_digit == 2'b11) y_eff = 2'b00;
  end

  assign bad_digit = accept & ((x_digit == 2'b11) | (y_digit == 2'b11));
`else
  assign x_eff = x_digit;
  assign y_eff = y_digit;
`endif

  // Control FSM plus operand storage; all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      x_plus    <= '0;
      x_minus   <= '0;
      y_plus    <= '0;
      y_minus   <= '0;
      digit_cnt <= '0;
      done      <= 1'b0;
`ifdef ONLINE_DIGIT_CHECK_EN
      dig_err   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (start) begin
        state_q   <= StLoad;
        x_plus    <= '0;
        x_minus   <= '0;
        y_plus    <= '0;
        y_minus   <= '0;
        digit_cnt <= '0;
`ifdef ONLINE_DIGIT_CHECK_EN
        dig_err   <= 1'b0;
`endif
      end else if (accept) begin
        x_plus    <= x_plus  | (pos & {NUM_DIGITS{x_eff[1]}});
        x_minus   <= x_minus | (pos & {NUM_DIGITS{x_eff[0]}});
        y_plus    <= y_plus  | (pos & {NUM_DIGITS{y_eff[1]}});
        y_minus   <= y_minus | (pos & {NUM_DIGITS{y_eff[0]}});
        digit_cnt <= digit_cnt + 1'b1;
`ifdef ONLINE_DIGIT_CHECK_EN
        if (bad_digit) dig_err <= 1'b1;
`endif
        if (last) begin
          state_q <= StFull;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_online_digit_reg.sv
// Directed self-checking bench for online_digit_reg: a 4-digit instance carries the main
// vectors, a 16-digit instance shares the stimulus to exercise parameter scaling.
module tb_online_digit_reg;

  localparam int unsigned ND  = 4;
  localparam int unsigned CW  = 4;
  localparam int unsigned ND2 = 16;
  localparam int unsigned CW2 = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic           in_valid;
  logic [1:0]     x_digit;
  logic [1:0]     y_digit;

  logic           in_ready;
  logic [ND-1:0]  x_plus, x_minus, y_plus, y_minus;
  logic [CW-1:0]  digit_cnt;
  logic           done;

  logic           in_ready16;
  logic [ND2-1:0] x_plus16, x_minus16, y_plus16, y_minus16;
  logic [CW2-1:0] digit_cnt16;
  logic           done16;

`ifdef ONLINE_DIGIT_CHECK_EN
  logic           dig_err;
  logic           dig_err16;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  online_digit_reg #(.NUM_DIGITS(ND), .CNT_W(CW)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_digit   (x_digit),
    .y_digit   (y_digit),
    .x_plus    (x_plus),
    .x_minus   (x_minus),
    .y_plus    (y_plus),
    .y_minus   (y_minus),
    .digit_cnt (digit_cnt),
    .done      (done)
`ifdef ONLINE_DIGIT_CHECK_EN
    ,
    .dig_err   (dig_err)
`endif
  );

  online_digit_reg #(.NUM_DIGITS(ND2), .CNT_W(CW2)) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready16),
    .x_digit   (x_digit),
    .y_digit   (y_digit),
    .x_plus    (x_plus16),
    .x_minus   (x_minus16),
    .y_plus    (y_plus16),
    .y_minus   (y_minus16),
    .digit_cnt (digit_cnt16),
    .done      (done16)
`ifdef ONLINE_DIGIT_CHECK_EN
    ,
    .dig_err   (dig_err16)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [ND-1:0] xp, input logic [ND-1:0] xm,
                         input logic [ND-1:0] yp, input logic [ND-1:0] ym);
    chk({tag, ".x_plus"},  32'(x_plus),  32'(xp));
    chk({tag, ".x_minus"}, 32'(x_minus), 32'(xm));
    chk({tag, ".y_plus"},  32'(y_plus),  32'(yp));
    chk({tag, ".y_minus"}, 32'(y_minus), 32'(ym));
  endtask

  // advance one clock; sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] xd, input logic [1:0] yd);
    in_valid = v;
    x_digit  = xd;
    y_digit  = yd;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] xs[4];
    logic [1:0] ys[4];
    logic [1:0] xo[6];
    logic [1:0] yo[6];
    xs = '{2'b10, 2'b01, 2'b00, 2'b10};
    ys = '{2'b01, 2'b01, 2'b10, 2'b00};
    xo = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10};
    yo = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b01, 2'b01};

    // reset
    rst_n = 1'b0;
    start = 1'b0;
    drive(1'b0, 2'b00, 2'b00);
    #12;
    chk_vec("rst", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    chk("rst.cnt", 32'(digit_cnt), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.in_ready", 32'(in_ready), 0);
`ifdef ONLINE_DIGIT_CHECK_EN
    chk("rst.dig_err", 32'(dig_err), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 2'b10, 2'b01);
    tick();
    tick();
    chk("idle.cnt", 32'(digit_cnt), 0);
    chk("idle.in_ready", 32'(in_ready), 0);
    chk("idle.x_plus", 32'(x_plus), 0);
    chk("idle.y_minus", 32'(y_minus), 0);
    drive(1'b0, 2'b00, 2'b00);

    // full back-to-back load
    do_start();
    chk("load.in_ready", 32'(in_ready), 1);
    chk("load.cnt0", 32'(digit_cnt), 0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, xs[i], ys[i]);
      tick();
      chk("load.cnt", 32'(digit_cnt), 32'(i + 1));
      chk("load.done", 32'(done), 32'(i == 3));
    end
    drive(1'b0, 2'b00, 2'b00);
    chk_vec("load", 4'b1001, 4'b0100, 4'b0010, 4'b1100);
    chk("load.in_ready_full", 32'(in_ready), 0);
    chk("scale.x_plus", 32'(x_plus16), 32'h9000);
    chk("scale.x_minus", 32'(x_minus16), 32'h4000);
    chk("scale.y_minus", 32'(y_minus16), 32'hC000);
    chk("scale.cnt", 32'(digit_cnt16), 4);
    chk("scale.done", 32'(done16), 0);
    chk("scale.in_ready", 32'(in_ready16), 1);
    tick();
    chk("load.done_end", 32'(done), 0);

    // backpressure gaps
    do_start();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, xs[i], ys[i]);
      tick();
      chk("gap.cnt_acc", 32'(digit_cnt), 32'(i + 1));
      drive(1'b0, 2'b11, 2'b11);
      tick();
      chk("gap.cnt_idle", 32'(digit_cnt), 32'(i + 1));
    end
    chk_vec("gap", 4'b1001, 4'b0100, 4'b0010, 4'b1100);

    // start with coincident digit, then abort after 2 digits
    start = 1'b1;
    drive(1'b1, 2'b10, 2'b10);
    tick();
    start = 1'b0;
    chk("prio.cnt", 32'(digit_cnt), 0);
    chk("prio.x_plus", 32'(x_plus), 0);
    chk("prio.in_ready", 32'(in_ready), 1);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, xs[i], ys[i]);
      tick();
    end
    chk("abort.cnt2", 32'(digit_cnt), 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    drive(1'b0, 2'b00, 2'b00);
    chk_vec("abort", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    chk("abort.cnt", 32'(digit_cnt), 0);
    chk("abort.done", 32'(done), 0);
    tick();
    chk("abort.done2", 32'(done), 0);

    // overflow: six digits presented, only four stored
    do_start();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, xo[i], yo[i]);
      tick();
      chk("ovf.done", 32'(done), 32'(i == 3));
    end
    drive(1'b0, 2'b00, 2'b00);
    chk_vec("ovf", 4'b0110, 4'b1001, 4'b1001, 4'b0010);
    chk("ovf.cnt", 32'(digit_cnt), 4);

    // undefined digit 11 at k=1
    do_start();
    drive(1'b1, 2'b10, 2'b00);
    tick();
    drive(1'b1, 2'b11, 2'b00);
    tick();
`ifdef ONLINE_DIGIT_CHECK_EN
    chk("chk.dig_err_set", 32'(dig_err), 1);
`endif
    drive(1'b1, 2'b01, 2'b00);
    tick();
    drive(1'b1, 2'b00, 2'b00);
    tick();
    drive(1'b0, 2'b00, 2'b00);
`ifdef ONLINE_DIGIT_CHECK_EN
    chk_vec("chk", 4'b1000, 4'b0010, 4'b0000, 4'b0000);
    chk("chk.dig_err_hold", 32'(dig_err), 1);
    do_start();
    chk("chk.dig_err_clr", 32'(dig_err), 0);
`else
    chk_vec("raw11", 4'b1100, 4'b0110, 4'b0000, 4'b0000);
    do_start();
`endif

    // async reset mid-load
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, xs[i], ys[i]);
      tick();
    end
    #3;
    rst_n = 1'b0;
    #1;
    chk_vec("arst", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    chk("arst.cnt", 32'(digit_cnt), 0);
    chk("arst.in_ready", 32'(in_ready), 0);
    #2;
    rst_n = 1'b1;
    drive(1'b1, 2'b10, 2'b10);
    tick();
    tick();
    chk("arst.idle_cnt", 32'(digit_cnt), 0);
    chk("arst.idle_x_plus", 32'(x_plus), 0);
    chk("arst.idle_in_ready", 32'(in_ready), 0);
    drive(1'b0, 2'b00, 2'b00);

    // full 16-digit load on the wide instance
    do_start();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, (i % 2 == 0) ? 2'b10 : 2'b01, (i % 4 == 0) ? 2'b01 : 2'b00);
      tick();
      chk("w16.done", 32'(done16), 32'(i == 15));
    end
    drive(1'b0, 2'b00, 2'b00);
    chk("w16.x_plus", 32'(x_plus16), 32'hAAAA);
    chk("w16.x_minus", 32'(x_minus16), 32'h5555);
    chk("w16.y_plus", 32'(y_plus16), 32'h0000);
    chk("w16.y_minus", 32'(y_minus16), 32'h8888);
    chk("w16.cnt", 32'(digit_cnt16), 16);
    chk("w16.in_ready", 32'(in_ready16), 0);
    chk_vec("w4", 4'b1010, 4'b0101, 4'b0000, 4'b1000);
    chk("w4.cnt", 32'(digit_cnt), 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
